// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port word memory between instruction fetch and
//            the load/store unit. It checks alignment, generates byte lanes and
//            formats load data. Misaligned accesses are returned as faults.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_fault,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_fault,
  output logic [3:0]        exc_cause,
  output logic [31:0]       exc_tval,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEM   = 2'd1,
    S_RESP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [3:0] C_CAUSE_FETCH = 4'd0;
  localparam logic [3:0] C_CAUSE_LOAD  = 4'd4;
  localparam logic [3:0] C_CAUSE_STORE = 4'd6;

  state_t r_state;
  state_t w_state_nxt;

  logic        r_grant_d;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_unsigned;

  logic        w_pick_d;
  logic        w_accept;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic        w_we;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [3:0]  w_cause;

  logic        w_resp;
  logic        w_done;
  logic        w_fault_st;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_fmt;

  // Request selection and decode of the access being offered in IDLE.
  always_comb begin
    w_pick_d = d_req && (DATA_FIRST || !if_req);
    w_accept = (r_state == S_IDLE) && (d_req || if_req);
    w_addr   = w_pick_d ? d_addr : if_addr;
    w_we     = w_pick_d && d_we;
    w_size   = w_pick_d ? d_size : 2'd2;   // a fetch is a word access

    case (w_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = w_addr[0];
      default: w_misaligned = |w_addr[1:0];
    endcase

    w_be    = 4'hF;
    w_wdata = '0;
    if (w_we) begin
      case (d_size)
        2'd0: begin
          w_be    = 4'b0001 << w_addr[1:0];
          w_wdata = {4{d_wdata[7:0]}};
        end
        2'd1: begin
          w_be    = 4'b0011 << w_addr[1:0];
          w_wdata = {2{d_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'hF;
          w_wdata = d_wdata;
        end
      endcase
    end

    if (!w_pick_d) begin
      w_cause = C_CAUSE_FETCH;
    end else if (d_we) begin
      w_cause = C_CAUSE_STORE;
    end else begin
      w_cause = C_CAUSE_LOAD;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_misaligned ? S_FAULT : S_MEM;
        end
      end
      S_MEM:   w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      S_FAULT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Attributes of the granted access, needed again when the response returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_d  <= 1'b0;
      r_lane     <= 2'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
    end else if (w_accept) begin
      r_grant_d  <= w_pick_d;
      r_lane     <= w_addr[1:0];
      r_size     <= w_size;
      r_unsigned <= d_unsigned;
    end
  end

  // Memory strobes are live only for the single MEM cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (w_accept && !w_misaligned) begin
      mem_en    <= 1'b1;
      mem_we    <= w_we;
      mem_be    <= w_be;
      mem_addr  <= w_addr[ADDR_W+1:2];
      mem_wdata <= w_wdata;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_cause <= 4'd0;
      exc_tval  <= 32'd0;
    end else if (w_accept && w_misaligned) begin
      exc_cause <= w_cause;
      exc_tval  <= w_addr;
    end
  end

  // Load formatting from the latched lane offset and size.
  always_comb begin
    w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      2'd0:    w_fmt = {{24{!r_unsigned && w_byte[7]}}, w_byte};
      2'd1:    w_fmt = {{16{!r_unsigned && w_half[15]}}, w_half};
      default: w_fmt = mem_rdata;
    endcase
  end

  assign w_resp     = (r_state == S_RESP);
  assign w_fault_st = (r_state == S_FAULT);
  assign w_done     = w_resp || w_fault_st;

  assign d_ready  = w_done && r_grant_d;
  assign d_fault  = w_fault_st && r_grant_d;
  assign d_rdata  = (w_resp && r_grant_d) ? w_fmt : 32'd0;
  assign if_ready = w_done && !r_grant_d;
  assign if_fault = w_fault_st && !r_grant_d;
  assign if_rdata = (w_resp && !r_grant_d) ? mem_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of memory contents and access rules.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_fault;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_ready, d_fault;
  logic [31:0] d_rdata;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        if_req2 = 1'b0;
  logic [31:0] if_addr2 = '0;
  logic        if_ready2, if_fault2;
  logic [31:0] if_rdata2;
  logic        d_req2 = 1'b0;
  logic [31:0] d_addr2 = '0;
  logic        d_ready2, d_fault2;
  logic [31:0] d_rdata2;
  logic [3:0]  exc_cause2;
  logic [31:0] exc_tval2;
  logic        mem_en2, mem_we2;
  logic [3:0]  mem_be2;
  logic [15:0] mem_addr2;
  logic [31:0] mem_wdata2;
  logic [31:0] mem_rdata2 = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] env_mem [0:65535];
  logic [31:0] ref_mem [0:65535];
  logic [3:0]  exp_cause = 4'd0;
  logic [31:0] exp_tval  = 32'd0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_fault(if_fault),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata), .d_fault(d_fault),
    .exc_cause(exc_cause), .exc_tval(exc_tval),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst),
    .if_req(if_req2), .if_addr(if_addr2), .if_ready(if_ready2), .if_rdata(if_rdata2), .if_fault(if_fault2),
    .d_req(d_req2), .d_we(1'b0), .d_size(2'd2), .d_unsigned(1'b0), .d_addr(d_addr2),
    .d_wdata(32'd0), .d_ready(d_ready2), .d_rdata(d_rdata2), .d_fault(d_fault2),
    .exc_cause(exc_cause2), .exc_tval(exc_tval2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_be(mem_be2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  // Synchronous-read memory seen by the main instance.
  always @(posedge clk) begin : env_ram
    logic [31:0] t;
    if (mem_en) begin
      t = env_mem[mem_addr];
      if (mem_we) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_be[i]) t[8*i +: 8] = mem_wdata[8*i +: 8];
        end
        env_mem[mem_addr] <= t;
      end
      mem_rdata <= env_mem[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (mem_en2) mem_rdata2 <= {16'hC0DE, mem_addr2};
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic misal(input int nb, input logic [31:0] a);
    return (a % nb) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [1:0] size, input logic [31:0] a);
    if (!we) return 4'hF;
    return 4'(((32'd1 << nbytes(size)) - 32'd1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] d);
    case (nbytes(size))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [31:0] a);
    int nb;
    logic [31:0] mask, v;
    nb = nbytes(size);
    if (nb == 4) return word;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = (word >> (8 * (a % 4))) & mask;
    if (!uns && (((v >> (8 * nb - 1)) & 32'd1) != 0)) v = v | ~mask;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Follows one data access already presented on d_*, from the next negedge on.
  task automatic await_data(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
    int en_cnt, en_cyc, rdy_cyc, w;
    logic [15:0] c_addr;
    logic [3:0]  c_be, be;
    logic        c_we, c_fault, if_seen, mis;
    logic [31:0] c_wdata, c_rdata, wd, t;
    mis = misal(nbytes(size), addr);
    w = int'((addr >> 2) & 32'hFFFF);
    en_cnt = 0; en_cyc = -1; rdy_cyc = -1; if_seen = 1'b0;
    c_addr = '0; c_be = '0; c_we = 1'b0; c_wdata = '0; c_rdata = '0; c_fault = 1'b0;
    for (int k = 1; k <= 8 && rdy_cyc < 0; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++; en_cyc = k;
        c_addr = mem_addr; c_be = mem_be; c_we = mem_we; c_wdata = mem_wdata;
      end
      if (if_ready) if_seen = 1'b1;
      if (d_ready) begin
        rdy_cyc = k; c_rdata = d_rdata; c_fault = d_fault; d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    check("d_ready_latency", rdy_cyc, mis ? 1 : 2);
    check("d_mem_en_count", en_cnt, mis ? 0 : 1);
    check("d_fault", 32'(c_fault), 32'(mis));
    check("if_ready_quiet", 32'(if_seen), 32'd0);
    if (mis) begin
      exp_cause = we ? 4'd6 : 4'd4;
      exp_tval  = addr;
    end else begin
      check("d_mem_en_cycle", en_cyc, 1);
      check("d_mem_addr", 32'(c_addr), w);
      check("d_mem_be", 32'(c_be), 32'(exp_be(we, size, addr)));
      check("d_mem_we", 32'(c_we), 32'(we));
      if (we) begin
        be = exp_be(we, size, addr);
        wd = exp_wdata(size, wdata);
        check("d_mem_wdata", c_wdata, wd);
        t = ref_mem[w];
        for (int i = 0; i < 4; i++) begin
          if (be[i]) t[8*i +: 8] = wd[8*i +: 8];
        end
        ref_mem[w] = t;
      end else begin
        check("d_rdata", c_rdata, exp_load(ref_mem[w], size, uns, addr));
      end
    end
    check("exc_cause", 32'(exc_cause), 32'(exp_cause));
    check("exc_tval", exc_tval, exp_tval);
  endtask

  task automatic do_data(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    await_data(we, size, uns, addr, wdata);
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    int en_cnt, rdy_cyc, w;
    logic [15:0] c_addr;
    logic [3:0]  c_be;
    logic        c_we, c_fault, d_seen, mis;
    logic [31:0] c_rdata;
    mis = misal(4, addr);
    w = int'((addr >> 2) & 32'hFFFF);
    en_cnt = 0; rdy_cyc = -1; d_seen = 1'b0;
    c_addr = '0; c_be = '0; c_we = 1'b0; c_rdata = '0; c_fault = 1'b0;
    @(negedge clk);
    if_addr = addr; if_req = 1'b1;
    for (int k = 1; k <= 8 && rdy_cyc < 0; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++; c_addr = mem_addr; c_be = mem_be; c_we = mem_we;
      end
      if (d_ready) d_seen = 1'b1;
      if (if_ready) begin
        rdy_cyc = k; c_rdata = if_rdata; c_fault = if_fault; if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    check("if_ready_latency", rdy_cyc, mis ? 1 : 2);
    check("if_mem_en_count", en_cnt, mis ? 0 : 1);
    check("if_fault", 32'(c_fault), 32'(mis));
    check("d_ready_quiet", 32'(d_seen), 32'd0);
    if (mis) begin
      exp_cause = 4'd0;
      exp_tval  = addr;
    end else begin
      check("if_mem_addr", 32'(c_addr), w);
      check("if_mem_be", 32'(c_be), 32'hF);
      check("if_mem_we", 32'(c_we), 32'd0);
      check("if_rdata", c_rdata, ref_mem[w]);
    end
    check("exc_cause", 32'(exc_cause), 32'(exp_cause));
    check("exc_tval", exc_tval, exp_tval);
  endtask

  initial begin : stim
    int d_at, i_at, d2_at, i2_at;
    logic [31:0] dv, iv, dv2, iv2, a;
    int r;

    for (int i = 0; i < 65536; i++) begin
      env_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    env_mem[16'h0010] = 32'hDEAD_BEEF;
    ref_mem[16'h0010] = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_exc_cause", 32'(exc_cause), 32'd0);
    check("rst_exc_tval", exc_tval, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;

    // Directed loads on word 0x10
    do_data(1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    do_data(1'b0, 2'd0, 1'b0, 32'h43, 32'd0);
    do_data(1'b0, 2'd0, 1'b1, 32'h43, 32'd0);
    do_data(1'b0, 2'd1, 1'b0, 32'h42, 32'd0);
    do_data(1'b0, 2'd1, 1'b1, 32'h40, 32'd0);
    check("lb_0x43_const", exp_load(ref_mem[16], 2'd0, 1'b0, 32'h43), 32'hFFFF_FFDE);

    // Directed stores on word 0x11 and read-back
    do_data(1'b1, 2'd1, 1'b0, 32'h46, 32'h0000_1234);
    do_data(1'b1, 2'd0, 1'b0, 32'h45, 32'h0000_00AB);
    do_data(1'b0, 2'd2, 1'b0, 32'h44, 32'd0);

    // Misaligned accesses
    do_data(1'b0, 2'd2, 1'b0, 32'h41, 32'd0);
    do_data(1'b1, 2'd1, 1'b0, 32'h43, 32'h5555);
    do_fetch(32'h102);
    do_fetch(32'h40);

    // Simultaneous requests on both arbitration polarities
    @(negedge clk);
    if_addr = 32'h40; if_req = 1'b1;
    d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h44; d_req = 1'b1;
    if_addr2 = 32'h80; if_req2 = 1'b1; d_addr2 = 32'h84; d_req2 = 1'b1;
    d_at = -1; i_at = -1; d2_at = -1; i2_at = -1;
    dv = '0; iv = '0; dv2 = '0; iv2 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (d_ready && d_at < 0)   begin d_at = k;  dv = d_rdata;   d_req = 1'b0;   end
      if (if_ready && i_at < 0)  begin i_at = k;  iv = if_rdata;  if_req = 1'b0;  end
      if (d_ready2 && d2_at < 0) begin d2_at = k; dv2 = d_rdata2; d_req2 = 1'b0;  end
      if (if_ready2 && i2_at < 0) begin i2_at = k; iv2 = if_rdata2; if_req2 = 1'b0; end
    end
    d_req = 1'b0; if_req = 1'b0; d_req2 = 1'b0; if_req2 = 1'b0;
    check("tie_df1_d_cycle", d_at, 2);
    check("tie_df1_if_cycle", i_at, 5);
    check("tie_df1_d_rdata", dv, ref_mem[16'h11]);
    check("tie_df1_if_rdata", iv, ref_mem[16'h10]);
    check("tie_df0_if_cycle", i2_at, 2);
    check("tie_df0_d_cycle", d2_at, 5);
    check("tie_df0_if_rdata", iv2, 32'hC0DE_0020);
    check("tie_df0_d_rdata", dv2, 32'hC0DE_0021);

    // Asynchronous reset while in MEM; the held load is served again afterwards
    @(negedge clk);
    d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    @(negedge clk);
    check("rst_mid_pre_en", 32'(mem_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_en_drop", 32'(mem_en), 32'd0);
    check("rst_mid_no_ready", 32'(d_ready), 32'd0);
    @(negedge clk);
    check("rst_mid_no_ready2", 32'(d_ready), 32'd0);
    rst = 1'b0;
    exp_cause = 4'd0;
    exp_tval  = 32'd0;
    await_data(1'b0, 2'd2, 1'b0, 32'h40, 32'd0);

    // Random mixed traffic over words 0x10..0x17 with ignored upper address bits
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 3));
      a = ($urandom & 32'hFFFC_0000) | (32'h40 + 32'($urandom_range(0, 31)));
      if (r == 0) begin
        do_fetch(a);
      end else begin
        do_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
